sent_tx_fast_frame: RTL and testbench

- SENT (SAE J2716) fast-channel transmitter; the transmit-side counterpart of the SENT receive path.
- Accepts a status nibble and up to 6 data nibbles over a valid/ready handshake.
- Computes the 4-bit SENT CRC and drives the single-wire pulse train: sync, status, data, CRC, and an optional pause.
- Sits between the sensor data source and the SENT output pad driver.

---
 rtl/sent_tx_fast_frame.sv | 178 +++++++++++++++++
 tb/tb_sent_tx_fast_frame.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sent_tx_fast_frame.sv
// SENT fast-channel transmitter: registers status/data, computes the 4-bit CRC, drives sync/status/data/CRC pulses.
// Optional PAUSE pulse padding the frame to FRAME_TICKS is built when SENT_TX_PAUSE_EN is defined.
module sent_tx_fast_frame #(
    parameter int TICK_DIV    = 4,
    parameter int NUM_NIBBLES = 6,
    parameter int LOW_TICKS   = 5,
    parameter int FRAME_TICKS = 282
) (
    input  logic        clk_tx,
    input  logic        reset,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [3:0]  status_in,
    input  logic [23:0] data_in,
    output logic        sent_out,
    output logic        busy,
    output logic        frame_done
);

    localparam int TW = $clog2(FRAME_TICKS + 64);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, SYNC, STATUS, DATA, CRC, PAUSE} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] pulse_len;
    logic [2:0]    nib_idx;
    logic [3:0]    status_q;
    logic [3:0]    crc_q;
    logic [3:0]    cur_nib;
    logic [23:0]   data_q;
    logic          tick_wrap;
    logic          pulse_end;
    logic          frame_last;
    logic          accept;
`ifdef SENT_TX_PAUSE_EN
    logic [TW-1:0] pause_len;
`endif

    function automatic logic [3:0] crc_tbl(input logic [3:0] i);
        logic [3:0] r;
        case (i)
            4'd0:  r = 4'd0;
            4'd1:  r = 4'd13;
            4'd2:  r = 4'd7;
            4'd3:  r = 4'd10;
            4'd4:  r = 4'd14;
            4'd5:  r = 4'd3;
            4'd6:  r = 4'd9;
            4'd7:  r = 4'd4;
            4'd8:  r = 4'd1;
            4'd9:  r = 4'd12;
            4'd10: r = 4'd6;
            4'd11: r = 4'd11;
            4'd12: r = 4'd15;
            4'd13: r = 4'd2;
            4'd14: r = 4'd8;
            default: r = 4'd5;
        endcase
        return r;
    endfunction

    // Seed 5, status nibble excluded, one extra table lookup at the end.
    function automatic logic [3:0] calc_crc(input logic [23:0] d);
        logic [3:0] c;
        c = 4'd5;
        for (int i = 0; i < NUM_NIBBLES; i++)
            c = crc_tbl(c) ^ d[20-4*i +: 4];
        return crc_tbl(c);
    endfunction

`ifdef SENT_TX_PAUSE_EN
    function automatic logic [TW-1:0] calc_pause(input logic [3:0] s, input logic [23:0] d);
        int p;
        p = FRAME_TICKS - 56 - 24 - int'(s) - int'(calc_crc(d));
        for (int i = 0; i < NUM_NIBBLES; i++)
            p = p - 12 - int'(d[20-4*i +: 4]);
        if (p < 12)
            p = 12;
        return TW'(p);
    endfunction
`endif

    always_comb begin
        case (nib_idx)
            3'd0:    cur_nib = data_q[23:20];
            3'd1:    cur_nib = data_q[19:16];
            3'd2:    cur_nib = data_q[15:12];
            3'd3:    cur_nib = data_q[11:8];
            3'd4:    cur_nib = data_q[7:4];
            default: cur_nib = data_q[3:0];
        endcase
        case (state)
            STATUS:  pulse_len = TW'(12) + TW'(status_q);
            DATA:    pulse_len = TW'(12) + TW'(cur_nib);
            CRC:     pulse_len = TW'(12) + TW'(crc_q);
`ifdef SENT_TX_PAUSE_EN
            PAUSE:   pulse_len = pause_len;
`endif
            default: pulse_len = TW'(56);
        endcase
    end

    assign tick_wrap  = (presc == PW'(TICK_DIV - 1));
    assign pulse_end  = tick_wrap && (tick_cnt == pulse_len - 1'b1);
`ifdef SENT_TX_PAUSE_EN
    assign frame_last = pulse_end && (state == PAUSE);
`else
    assign frame_last = pulse_end && (state == CRC);
`endif
    assign tx_ready   = (state == IDLE) || frame_last;
    assign accept     = tx_valid && tx_ready;
    assign frame_done = frame_last;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk_tx) begin
        if (reset) begin
            state    <= IDLE;
            presc    <= '0;
            tick_cnt <= '0;
            nib_idx  <= '0;
            status_q <= '0;
            data_q   <= '0;
            crc_q    <= '0;
            sent_out <= 1'b1;
`ifdef SENT_TX_PAUSE_EN
            pause_len <= '0;
`endif
        end else if (accept) begin
            status_q <= status_in;
            data_q   <= data_in;
            crc_q    <= calc_crc(data_in);
`ifdef SENT_TX_PAUSE_EN
            pause_len <= calc_pause(status_in, data_in);
`endif
            state    <= SYNC;
            presc    <= '0;
            tick_cnt <= '0;
            nib_idx  <= '0;
            sent_out <= 1'b0;
        end else if (state != IDLE) begin
            if (!tick_wrap) begin
                presc <= presc + 1'b1;
            end else begin
                presc <= '0;
                if (pulse_end) begin
                    // Every new pulse opens with its low phase.
                    tick_cnt <= '0;
                    sent_out <= 1'b0;
                    case (state)
                        SYNC:   state <= STATUS;
                        STATUS: state <= DATA;
                        DATA: begin
                            if (nib_idx == 3'(NUM_NIBBLES - 1))
                                state <= CRC;
                            else
                                nib_idx <= nib_idx + 1'b1;
                        end
`ifdef SENT_TX_PAUSE_EN
                        CRC:    state <= PAUSE;
`endif
                        default: begin
                            state    <= IDLE;
                            sent_out <= 1'b1;
                        end
                    endcase
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                    if (tick_cnt == TW'(LOW_TICKS - 1))
                        sent_out <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sent_tx_fast_frame.sv
// Scoreboard bench: stimulus pushes expected pulse and frame lengths, a negedge monitor measures the line.
module tb_sent_tx_fast_frame;

    typedef struct {int len; int low;} pulse_t;
    typedef struct {int total; bit b2b;} frame_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic        r0, r1, s0, s1, b0, b1, fd0, fd1;
    logic [3:0]  status_in = '0;
    logic [23:0] data_in = '0;

    int n_tests = 0;
    int n_fail  = 0;

    pulse_t exp_q[$];
    frame_t frm_q[$];
    frame_t cur;
    int     sel = 0;
    bit     flush = 1'b0;
    bit     prev = 1'b1, in_pulse = 1'b0, in_frame = 1'b0;
    int     pcnt, plow, fclk, rdy_cnt, gap;

    sent_tx_fast_frame dut0 (
        .clk_tx(clk), .reset(reset), .tx_valid(v0), .tx_ready(r0),
        .status_in(status_in), .data_in(data_in),
        .sent_out(s0), .busy(b0), .frame_done(fd0)
    );

    sent_tx_fast_frame #(.TICK_DIV(1), .NUM_NIBBLES(3)) dut1 (
        .clk_tx(clk), .reset(reset), .tx_valid(v1), .tx_ready(r1),
        .status_in(status_in), .data_in(data_in),
        .sent_out(s1), .busy(b1), .frame_done(fd1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic close_pulse();
        pulse_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_pulse", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("pulse_len", pcnt, e.len);
            check("pulse_low", plow, e.low);
        end
        in_pulse = 1'b0;
    endtask

    // Monitor: measures pulses and frames on the selected instance.
    always @(negedge clk) begin
        logic so, fd, rd;
        if (flush) begin
            exp_q.delete();
            frm_q.delete();
            in_pulse = 1'b0;
            in_frame = 1'b0;
            prev     = 1'b1;
            flush    = 1'b0;
        end else if (!reset) begin
            so = (sel != 0) ? s1 : s0;
            fd = (sel != 0) ? fd1 : fd0;
            rd = (sel != 0) ? r1 : r0;
            if (prev && !so) begin
                if (in_pulse)
                    close_pulse();
                if (!in_frame) begin
                    if (frm_q.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                        cur = '{0, 1'b0};
                    end else begin
                        cur = frm_q.pop_front();
                        if (cur.b2b)
                            check("b2b_gap", gap, 0);
                    end
                    in_frame = 1'b1;
                    fclk     = 0;
                    rdy_cnt  = 0;
                end
                in_pulse = 1'b1;
                pcnt     = 0;
                plow     = 0;
            end
            if (in_pulse) begin
                pcnt++;
                if (!so)
                    plow++;
            end
            if (in_frame) begin
                fclk++;
                if (rd)
                    rdy_cnt++;
            end else begin
                gap++;
            end
            if (fd) begin
                if (!in_frame) begin
                    check("stray_frame_done", 1, 0);
                end else begin
                    if (in_pulse)
                        close_pulse();
                    check("frame_clocks", fclk, cur.total);
                    check("ready_in_frame", rdy_cnt, 1);
                    in_frame = 1'b0;
                end
                gap = 0;
            end
            prev = so;
        end
    end

    task automatic push_pulse(input int ticks, input int td, inout int sum);
        exp_q.push_back('{ticks * td, 5 * td});
        sum += ticks;
    endtask

    task automatic send(input int s, input logic [3:0] st, input logic [23:0] d,
                        input logic [3:0] crc, input bit b2b, input bit keep);
        int td, nn, sum, p, k;
        logic [23:0] dv;
        bit got;
        td  = (s != 0) ? 1 : 4;
        nn  = (s != 0) ? 3 : 6;
        sum = 0;
        dv  = d;
        push_pulse(56, td, sum);
        push_pulse(12 + int'(st), td, sum);
        for (int i = 0; i < nn; i++)
            push_pulse(12 + int'(dv[20-4*i +: 4]), td, sum);
        push_pulse(12 + int'(crc), td, sum);
`ifdef SENT_TX_PAUSE_EN
        p = 282 - sum;
        if (p < 12)
            p = 12;
        push_pulse(p, td, sum);
`else
        p = 0;
`endif
        frm_q.push_back('{sum * td + p * 0, b2b});
        @(negedge clk);
        status_in = st;
        data_in   = d;
        if (s != 0) v1 = 1'b1; else v0 = 1'b1;
        got = 1'b0;
        for (k = 0; k < 3000; k++) begin
            if (((s != 0) ? r1 : r0) == 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got)
            check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!keep) begin
            v0 = 1'b0;
            v1 = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && frm_q.size() == 0 && !b0 && !b1)
                break;
        end
        check("drain_pulses_left", exp_q.size(), 0);
        check("drain_frames_left", frm_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_sent_out", int'(s0), 1);
        check("rst_tx_ready", int'(r0), 1);
        check("rst_busy", int'(b0), 0);
        check("rst_frame_done", int'(fd0), 0);

        // All-zero frame: CRC 5, 157 ticks.
        send(0, 4'h0, 24'h000000, 4'h5, 1'b0, 1'b0);
        wait_idle();
        // Status 3, first nibble 1: CRC D.
        send(0, 4'h3, 24'h100000, 4'hD, 1'b0, 1'b0);
        wait_idle();

        // Three frames back to back, valid held high.
        send(0, 4'h5, 24'h123456, 4'h2, 1'b0, 1'b1);
        send(0, 4'h0, 24'h000000, 4'h5, 1'b1, 1'b1);
        send(0, 4'hF, 24'hFFFFFF, 4'hA, 1'b1, 1'b0);
        wait_idle();

        // Reset in the middle of the data nibbles.
        send(0, 4'h0, 24'h000000, 4'h5, 1'b0, 1'b0);
        repeat (400) @(negedge clk);
        check("mid_busy_before_reset", int'(b0), 1);
        reset = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("abort_sent_out", int'(s0), 1);
        check("abort_busy", int'(b0), 0);
        check("abort_tx_ready", int'(r0), 1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        send(0, 4'h0, 24'h000000, 4'h5, 1'b0, 1'b0);
        wait_idle();

        // Short instance: three nibbles, one clock per tick, low bits ignored.
        sel = 1;
        send(1, 4'h6, 24'hABC123, 4'h1, 1'b0, 1'b0);
        wait_idle();
        send(1, 4'h6, 24'hABCFFF, 4'h1, 1'b0, 1'b0);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
